nm_c2n_tx: RTL

NM_C2N_TX -- requirements
Module: nm_c2n_tx

---
 rtl/nm_c2n_tx_if.sv | 29 ++
 rtl/nm_c2n_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nm_c2n_tx_if.sv
// Command-write and serial-output bundle for the nm_c2n_tx C2N serializer.
// The master drives writes and emulation controls. The slave returns the serial lines and the status.
interface nm_c2n_tx_if #(
    parameter int NUM_CH = 2,
    parameter int WORD_W = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [WORD_W-1:0] wr_data;
    logic [NUM_CH-1:0] emulate;
    logic              ovf_clr;
    logic [NUM_CH-1:0] c2n_data;
    logic [NUM_CH-1:0] c2n_valid;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] busy;
    logic              ovf_irq;

    modport master (
        output wr_en, wr_ch, wr_data, emulate, ovf_clr,
        input  c2n_data, c2n_valid, fifo_full, fifo_empty, busy, ovf_irq
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, emulate, ovf_clr,
        output c2n_data, c2n_valid, fifo_full, fifo_empty, busy, ovf_irq
    );
endinterface

// File: rtl/nm_c2n_tx.sv
// Multi-channel C2N command transmitter.
// Each channel has a per-channel word FIFO feeding an MSB-first serializer, and the serializer inserts an inter-word gap.
module nm_c2n_tx #(
    parameter int NUM_CH     = 2,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_DIV    = 4
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    nm_c2n_tx_if.slave bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int BW   = $clog2(WORD_W);
    localparam int HW   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [WORD_W-1:0] mem_q   [NUM_CH][FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d   [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]     wp_q    [NUM_CH];
    logic [PW-1:0]     wp_d    [NUM_CH];
    logic [PW-1:0]     rp_q    [NUM_CH];
    logic [PW-1:0]     rp_d    [NUM_CH];
    logic [WORD_W-1:0] shreg_q [NUM_CH];
    logic [WORD_W-1:0] shreg_d [NUM_CH];
    logic [BW-1:0]     bit_q   [NUM_CH];
    logic [BW-1:0]     bit_d   [NUM_CH];
    logic [HW-1:0]     hold_q  [NUM_CH];
    logic [HW-1:0]     hold_d  [NUM_CH];

    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] full_q, full_d;
    logic [NUM_CH-1:0] empty_q, empty_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              irq_q, irq_d;

    // Next-state logic: FIFO push/pop, overflow flags and the per-channel serializer FSM.
    always_comb begin
        logic              hit_s;
        logic              pop_s;
        logic [WORD_W-1:0] head_s;
        hit_s   = 1'b0;
        pop_s   = 1'b0;
        head_s  = {WORD_W{1'b0}};
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        data_d  = data_q;
        busy_d  = busy_q;
        full_d  = full_q;
        empty_d = empty_q;
        ovf_d   = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            // Out-of-range channel indices match no channel, so they are dropped silently.
            hit_s  = bus.wr_en && (bus.wr_ch == CH_W'(i));
            pop_s  = (state_q[i] == ST_IDLE) && !empty_q[i];
            head_s = mem_q[i][rp_q[i][AW-1:0]];

            if (hit_s && !full_q[i]) begin
                mem_d[i][wp_q[i][AW-1:0]] = bus.wr_data;
                wp_d[i] = wp_q[i] + PW'(1);
            end else begin
                wp_d[i] = wp_q[i];
            end

            if (pop_s) begin
                rp_d[i] = rp_q[i] + PW'(1);
            end else begin
                rp_d[i] = rp_q[i];
            end

            full_d[i]  = (wp_d[i][PW-1] != rp_d[i][PW-1]) && (wp_d[i][AW-1:0] == rp_d[i][AW-1:0]);
            empty_d[i] = (wp_d[i] == rp_d[i]);

            // A new overflow outranks a simultaneous clear.
            if (hit_s && full_q[i]) begin
                ovf_d[i] = 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_d[i] = 1'b0;
            end else begin
                ovf_d[i] = ovf_q[i];
            end

            case (state_q[i])
                ST_IDLE: begin
                    if (pop_s) begin
                        state_d[i] = ST_SHIFT;
                        shreg_d[i] = head_s;
                        bit_d[i]   = BW'(0);
                        hold_d[i]  = HW'(0);
                        valid_d[i] = 1'b1;
                        data_d[i]  = head_s[WORD_W-1];
                    end else begin
                        valid_d[i] = 1'b0;
                        data_d[i]  = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (hold_q[i] == HOLD_LAST) begin
                        hold_d[i] = HW'(0);
                        if (bit_q[i] == BIT_LAST) begin
                            state_d[i] = ST_GAP;
                            bit_d[i]   = BW'(0);
                            shreg_d[i] = {WORD_W{1'b0}};
                            valid_d[i] = 1'b0;
                            data_d[i]  = 1'b0;
                        end else begin
                            bit_d[i]   = bit_q[i] + BW'(1);
                            shreg_d[i] = shreg_q[i] << 1;
                            valid_d[i] = 1'b1;
                            data_d[i]  = shreg_q[i][WORD_W-2];
                        end
                    end else begin
                        hold_d[i] = hold_q[i] + HW'(1);
                    end
                end
                ST_GAP: begin
                    if (hold_q[i] == HOLD_LAST) begin
                        hold_d[i]  = HW'(0);
                        state_d[i] = ST_IDLE;
                    end else begin
                        hold_d[i] = hold_q[i] + HW'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    valid_d[i] = 1'b0;
                    data_d[i]  = 1'b0;
                end
            endcase

            busy_d[i] = (state_d[i] != ST_IDLE);
        end
        irq_d = |ovf_d;
    end

    // State registers; reset aborts any word in flight and discards queued words.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                wp_q[i]    <= PW'(0);
                rp_q[i]    <= PW'(0);
                shreg_q[i] <= {WORD_W{1'b0}};
                bit_q[i]   <= BW'(0);
                hold_q[i]  <= HW'(0);
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_q[i][j] <= {WORD_W{1'b0}};
                end
            end
            valid_q <= {NUM_CH{1'b0}};
            data_q  <= {NUM_CH{1'b0}};
            busy_q  <= {NUM_CH{1'b0}};
            full_q  <= {NUM_CH{1'b0}};
            empty_q <= {NUM_CH{1'b1}};
            ovf_q   <= {NUM_CH{1'b0}};
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    // Emulation only blanks the line; the channel keeps consuming words underneath.
    assign bus.c2n_data   = data_q & ~bus.emulate;
    assign bus.c2n_valid  = valid_q & ~bus.emulate;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.busy       = busy_q;
    assign bus.ovf_irq    = irq_q;
endmodule
